// File: rtl/i2c_slave_receive_byte.sv
// I2C target byte receiver: detects START/STOP, matches a 7-bit write address, ACKs and delivers data bytes.
// Optional clock stretching until the consumer acknowledges is enabled by defining I2C_SLAVE_RX_STRETCH_EN.
module i2c_slave_receive_byte #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2       // must be at least 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    input  logic       ack_enable,
    input  logic       rd_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } stateType;

    stateType state;
    stateType stateNext;

    logic [SYNC_STAGES-1:0] sclSync;
    logic [SYNC_STAGES-1:0] sdaSync;
    logic                   sclS;
    logic                   sdaS;
    logic                   sclPrev;
    logic                   sdaPrev;
    logic                   sclRise;
    logic                   sclFall;
    logic                   startEv;
    logic                   stopEv;
    logic                   sdaBit;

    logic [6:0] shiftReg;
    logic [2:0] bitCnt;
    logic       ackPhase;
    logic       ackGiven;
    logic       addrMatch;
    logic       byteDone;

    logic       sdaOe;
    logic       sclOe;
    logic       addressedQ;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       startDet;
    logic       stopDet;

    logic       sdaOeNext;
    logic       sclOeNext;
    logic       addressedNext;
    logic [7:0] dataOutNext;
    logic       dataValidNext;

    // Synchronisers idle high so reset release never looks like a bus edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclSync <= '1;
            sdaSync <= '1;
        end else begin
            sclSync <= {sclSync[SYNC_STAGES-2:0], scl_in};
            sdaSync <= {sdaSync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign sclS = sclSync[SYNC_STAGES-1];
    assign sdaS = sdaSync[SYNC_STAGES-1];

    // Registered bus events; sdaBit holds the SDA level seen alongside sclRise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
            sclRise <= 1'b0;
            sclFall <= 1'b0;
            startEv <= 1'b0;
            stopEv  <= 1'b0;
            sdaBit  <= 1'b1;
        end else begin
            sclPrev <= sclS;
            sdaPrev <= sdaS;
            sclRise <= sclS & ~sclPrev;
            sclFall <= ~sclS & sclPrev;
            startEv <= sclS & sclPrev & sdaPrev & ~sdaS;
            stopEv  <= sclS & sclPrev & ~sdaPrev & sdaS;
            sdaBit  <= sdaS;
        end
    end

    assign byteDone  = sclRise && (bitCnt == 3'd7);
    assign addrMatch = (shiftReg == SLAVE_ADDR) && !sdaBit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        if (startEv) begin
            stateNext = ADDR;
        end else if (stopEv) begin
            stateNext = IDLE;
        end else begin
            case (state)
                ADDR: begin
                    if (byteDone) begin
                        stateNext = addrMatch ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: begin
                    if (sclFall && ackPhase) begin
                        stateNext = DATA;
                    end
                end
                DATA: begin
                    if (byteDone) begin
                        stateNext = DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    if (sclFall && ackPhase) begin
                        stateNext = ackGiven ? DATA : IGNORE;
                    end
                end
                default: stateNext = state;
            endcase
        end
    end

    // ackPhase separates the 8th SCL fall (start driving) from the 9th (release).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftReg <= '0;
            bitCnt   <= '0;
            ackPhase <= 1'b0;
            ackGiven <= 1'b0;
        end else if (startEv || stopEv) begin
            bitCnt   <= '0;
            ackPhase <= 1'b0;
        end else begin
            case (state)
                ADDR, DATA: begin
                    if (sclRise) begin
                        shiftReg <= {shiftReg[5:0], sdaBit};
                        bitCnt   <= bitCnt + 3'd1;
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        ackPhase <= !ackPhase;
                    end
                end
                DATA_ACK: begin
                    if (sclFall) begin
                        ackPhase <= !ackPhase;
                        if (!ackPhase) begin
                            ackGiven <= ack_enable;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef I2C_SLAVE_RX_STRETCH_EN
    // rdSeen remembers an rd_ack that arrived before the 8th fall, so no stretch is needed.
    logic rdSeen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdSeen <= 1'b0;
        end else if (startEv || stopEv || dataValidNext) begin
            rdSeen <= 1'b0;
        end else if (rd_ack) begin
            rdSeen <= 1'b1;
        end
    end
`else
    logic unusedRdAck;
    assign unusedRdAck = rd_ack;
`endif

    always_comb begin
        sdaOeNext     = sdaOe;
        sclOeNext     = sclOe;
        addressedNext = addressedQ;
        dataOutNext   = dataOut;
        dataValidNext = 1'b0;
`ifdef I2C_SLAVE_RX_STRETCH_EN
        if (sclOe && rd_ack) begin
            sclOeNext = 1'b0;
        end
`endif
        if (startEv || stopEv) begin
            sdaOeNext     = 1'b0;
            sclOeNext     = 1'b0;
            addressedNext = 1'b0;
        end else begin
            case (state)
                ADDR_ACK: begin
                    if (sclFall) begin
                        if (!ackPhase) begin
                            sdaOeNext     = 1'b1;
                            addressedNext = 1'b1;
                        end else begin
                            sdaOeNext = 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (byteDone) begin
                        dataOutNext   = {shiftReg, sdaBit};
                        dataValidNext = 1'b1;
                    end
                end
                DATA_ACK: begin
                    if (sclFall) begin
                        if (!ackPhase) begin
                            sdaOeNext = ack_enable;
`ifdef I2C_SLAVE_RX_STRETCH_EN
                            sclOeNext = !(rdSeen || rd_ack);
`endif
                        end else begin
                            sdaOeNext = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
`ifndef I2C_SLAVE_RX_STRETCH_EN
        sclOeNext = 1'b0;
`endif
    end

    // Pad enables reset asynchronously, so the bus is released the moment reset asserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdaOe      <= 1'b0;
            sclOe      <= 1'b0;
            addressedQ <= 1'b0;
            dataOut    <= 8'h00;
            dataValid  <= 1'b0;
            startDet   <= 1'b0;
            stopDet    <= 1'b0;
        end else begin
            sdaOe      <= sdaOeNext;
            sclOe      <= sclOeNext;
            addressedQ <= addressedNext;
            dataOut    <= dataOutNext;
            dataValid  <= dataValidNext;
            startDet   <= startEv;
            stopDet    <= stopEv;
        end
    end

    assign sda_oe     = sdaOe;
    assign scl_oe     = sclOe;
    assign addressed  = addressedQ;
    assign data_out   = dataOut;
    assign data_valid = dataValid;
    assign start_det  = startDet;
    assign stop_det   = stopDet;

endmodule

// File: tb/tb_i2c_slave_receive_byte.sv
// Scoreboard bench for i2c_slave_receive_byte: a bus-master model drives open-drain SCL/SDA,
// expected bytes go into a queue and a monitor pops them whenever data_valid pulses.
module tb_i2c_slave_receive_byte;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclM = 1'b1;
    logic       sdaM = 1'b1;
    logic       ack_enable = 1'b1;
    logic       rd_ack;
    logic       sda_oe;
    logic       scl_oe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       addressed;
    logic       start_det;
    logic       stop_det;
    logic       sclLine;
    logic       sdaLine;

    int checks = 0;
    int fails = 0;
    int startCnt = 0;
    int stopCnt = 0;
    int expStart = 0;
    int expStop = 0;
    logic busIdle = 1'b1;
    logic [7:0] expQ[$];
    logic [7:0] txData[4];
    logic       txAck[4];
`ifdef I2C_SLAVE_RX_STRETCH_EN
    logic stretchTest = 1'b0;
    logic autoRdAck = 1'b0;
`endif

    assign sclLine = sclM & ~scl_oe;
    assign sdaLine = sdaM & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_receive_byte #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (sclLine),
        .sda_in    (sdaLine),
        .sda_oe    (sda_oe),
        .scl_oe    (scl_oe),
        .ack_enable(ack_enable),
        .rd_ack    (rd_ack),
        .data_out  (data_out),
        .data_valid(data_valid),
        .addressed (addressed),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts event pulses and scores every delivered byte against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (start_det) startCnt++;
            if (stop_det) stopCnt++;
            if (data_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_data_valid: got 0x%02h, expected no byte", data_out);
                end else begin
                    check("data_out", data_out, expQ.pop_front());
                end
            end
        end
    end

    // Consumer model driving rd_ack.
    initial begin
        rd_ack = 1'b0;
        forever begin
            @(negedge clk);
`ifdef I2C_SLAVE_RX_STRETCH_EN
            if (!stretchTest) begin
                rd_ack = 1'b1;
            end else if (autoRdAck && data_valid) begin
                rd_ack = 1'b0;
                repeat (50) @(negedge clk);
                check("scl_oe_held", scl_oe, 1);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
                check("scl_oe_released", scl_oe, 0);
            end else begin
                rd_ack = 1'b0;
            end
`else
            rd_ack = 1'($urandom_range(0, 1));
`endif
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    task automatic waitSclHigh();
        for (int i = 0; i < 2000; i++) begin
            if (sclLine) break;
            @(negedge clk);
        end
        if (!sclLine) check("scl_release_timeout", sclLine, 1);
    endtask

    task automatic sendBit(input logic b, input logic chkIdle, output logic line);
        sdaM = b;
        waitQ();
        sclM = 1'b1;
        waitSclHigh();
        waitQ();
        line = sdaLine;
        if (chkIdle) check("pads_released_in_data", {sda_oe, scl_oe}, 0);
        sclM = 1'b0;
        waitQ();
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        logic line;
        for (int i = 7; i >= 0; i--) sendBit(b[i], 1'b1, line);
        sendBit(1'b1, 1'b0, line);
        ack = !line;
    endtask

    task automatic i2cStart();
        sdaM = 1'b0;
        waitQ();
        sclM = 1'b0;
        waitQ();
        expStart++;
        busIdle = 1'b0;
    endtask

    task automatic i2cRepStart();
        sdaM = 1'b1;
        waitQ();
        sclM = 1'b1;
        waitSclHigh();
        waitQ();
        sdaM = 1'b0;
        waitQ();
        sclM = 1'b0;
        waitQ();
        expStart++;
    endtask

    task automatic i2cStop();
        sdaM = 1'b0;
        waitQ();
        sclM = 1'b1;
        waitSclHigh();
        waitQ();
        sdaM = 1'b1;
        waitQ();
        expStop++;
        busIdle = 1'b1;
        check("stop_count", stopCnt, expStop);
        check("addressed_after_stop", addressed, 0);
    endtask

    // Reference rules: only a write to 0x50 is ACKed; each data byte is delivered while the
    // target is still engaged, and a NACKed data byte disengages it until the next START.
    task automatic doTransfer(input logic [7:0] addr, input int n, input logic endStop);
        logic ack;
        logic active;
        logic wasAddressed;
        active = (addr[7:1] == 7'h50) && (addr[0] == 1'b0);
        wasAddressed = active;
        if (busIdle) i2cStart();
        else i2cRepStart();
        sendByte(addr, ack);
        check("addr_ack", ack, active);
        check("addressed_after_addr", addressed, active);
        for (int i = 0; i < n; i++) begin
            ack_enable = txAck[i];
            if (active) expQ.push_back(txData[i]);
            sendByte(txData[i], ack);
            check("data_ack", ack, active && txAck[i]);
            check("pending_bytes", expQ.size(), 0);
            if (active && !txAck[i]) active = 1'b0;
        end
        check("addressed_hold", addressed, wasAddressed);
        check("start_count", startCnt, expStart);
        if (endStop) i2cStop();
    endtask

    task automatic midReset();
        #2 reset = 1'b1;
        #1;
        check("reset_sda_oe_async", sda_oe, 0);
        check("reset_scl_oe_async", scl_oe, 0);
        sclM = 1'b1;
        sdaM = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 8'h00);
        check("reset_addressed", addressed, 0);
        check("reset_data_valid", data_valid, 0);
        reset = 1'b0;
        busIdle = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic ack;
        logic line;
        logic [7:0] b;

        repeat (2) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 0);
        check("rst_addressed", addressed, 0);
        check("rst_start_det", start_det, 0);
        check("rst_stop_det", stop_det, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Write 0x3C to our address.
        txData[0] = 8'h3C; txAck[0] = 1'b1;
        doTransfer(8'hA0, 1, 1'b1);

        // Other address: never driven, nothing delivered.
        txData[0] = 8'hFF; txAck[0] = 1'b1;
        txData[1] = 8'h00; txAck[1] = 1'b1;
        doTransfer(8'hA2, 2, 1'b1);

        // Read of our address is NACKed and ignored.
        txData[0] = 8'h5A; txAck[0] = 1'b1;
        doTransfer(8'hA1, 1, 1'b1);

        // Repeated START between two writes.
        txData[0] = 8'h55; txAck[0] = 1'b1;
        doTransfer(8'hA0, 1, 1'b0);
        txData[0] = 8'hAA; txAck[0] = 1'b1;
        doTransfer(8'hA0, 1, 1'b1);

        // NACKed data byte disengages the target.
        txData[0] = 8'h12; txAck[0] = 1'b0;
        txData[1] = 8'h34; txAck[1] = 1'b1;
        doTransfer(8'hA0, 2, 1'b1);

        // STOP in the middle of a data byte: the partial byte is dropped.
        ack_enable = 1'b1;
        i2cStart();
        sendByte(8'hA0, ack);
        check("partial_addr_ack", ack, 1);
        for (int i = 0; i < 4; i++) sendBit(1'(i % 2), 1'b1, line);
        i2cStop();

        // Reset while the address ACK is being driven.
        i2cStart();
        b = 8'hA0;
        for (int i = 7; i >= 0; i--) sendBit(b[i], 1'b1, line);
        repeat (6) @(negedge clk);
        check("ack_driven_before_reset", sda_oe, 1);
        midReset();

`ifdef I2C_SLAVE_RX_STRETCH_EN
        stretchTest = 1'b1;
        autoRdAck = 1'b1;
        txData[0] = 8'h7E; txAck[0] = 1'b1;
        doTransfer(8'hA0, 1, 1'b1);

        // Reset while SCL is being stretched.
        autoRdAck = 1'b0;
        i2cStart();
        sendByte(8'hA0, ack);
        check("stretch_addr_ack", ack, 1);
        b = 8'h55;
        expQ.push_back(b);
        for (int i = 7; i >= 0; i--) sendBit(b[i], 1'b1, line);
        for (int i = 0; i < 40; i++) begin
            if (scl_oe) break;
            @(negedge clk);
        end
        check("stretch_active", scl_oe, 1);
        check("stretch_ack_ready", sda_oe, 1);
        midReset();
        stretchTest = 1'b0;
`endif

        // Randomized transfers.
        for (int t = 0; t < 16; t++) begin
            logic [7:0] addr;
            int n;
            addr = ($urandom_range(0, 2) != 0) ? 8'hA0 : 8'($urandom);
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                txData[i] = 8'($urandom);
                txAck[i] = ($urandom_range(0, 3) != 0);
            end
            doTransfer(addr, n, (t == 15) || ($urandom_range(0, 1) == 1));
        end

        repeat (20) @(negedge clk);
        check("queue_drained", expQ.size(), 0);
        check("final_start_count", startCnt, expStart);
        check("final_stop_count", stopCnt, expStop);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
